// File: rtl/canvas_renderer.sv
// canvas_renderer: pipelined colour mapper for the digit-drawing canvas.
// Holds the GRID_N x GRID_N canvas in a simple dual-port RAM. Each screen
// pixel is mapped to a cell, and the cell's intensity is shaded in grey.
// A red cursor disc and optional grid lines are drawn over it.
// RGB output is registered two cycles after pix_valid.
//
// Clear FSM states:
//   state    | meaning
//   ST_IDLE  | canvas idle, external writes accepted
//   ST_CLEAR | zeroing one canvas word per cycle, busy=1
module canvas_renderer #(
   parameter int GRID_N    = 28,
   parameter int CELL_PX   = 14,
   parameter int ORIGIN_X  = 200,
   parameter int ORIGIN_Y  = 44,
   parameter int PIX_W     = 16,
   parameter int SHADE_LSB = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             pix_valid,
   input  logic [9:0]       DrawX,
   input  logic [9:0]       DrawY,
   input  logic [9:0]       BallX,
   input  logic [9:0]       BallY,
   input  logic [9:0]       Ball_size,
   input  logic             grid_en,
   input  logic             wr_en,
   input  logic [4:0]       wr_x,
   input  logic [4:0]       wr_y,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             clear,
   output logic             busy,
   output logic             out_valid,
   output logic [7:0]       Red,
   output logic [7:0]       Green,
   output logic [7:0]       Blue
);

   localparam int DEPTH = GRID_N * GRID_N;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [9:0]    ORIGIN_X_W = 10'(ORIGIN_X);
   localparam logic [9:0]    ORIGIN_Y_W = 10'(ORIGIN_Y);
   localparam logic [9:0]    CELL_W     = 10'(CELL_PX);
   localparam logic [10:0]   CANVAS_W   = 11'(GRID_N * CELL_PX);
   localparam logic [5:0]    GRID_W     = 6'(GRID_N);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // clear FSM
   logic [0:0]    state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;

   // canvas RAM
   logic [PIX_W-1:0] mem [DEPTH];
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [PIX_W-1:0] mem_wdata;
   logic [AW-1:0]    rd_addr_d;
   logic [PIX_W-1:0] rd_data_q;

   // stage 0 geometry
   logic [9:0]  rx, ry;
   logic [9:0]  cx, cy;
   logic [9:0]  rx_mod, ry_mod;
   logic        canvas_on;
   logic        line_on;
   logic [10:0] dx, dy, adx, ady;
   logic [21:0] dist2, rad2;
   logic        ball_on;

   // stage 1 flags
   logic s1_valid_q, s1_valid_d;
   logic s1_ball_q,  s1_ball_d;
   logic s1_line_q,  s1_line_d;
   logic s1_canvas_q, s1_canvas_d;

   // stage 2 outputs
   logic [PIX_W-1:0] shifted;
   logic [PIX_W-1:0] shade_hi;
   logic [7:0]       shade;
   logic [23:0]      colour;
   logic [23:0]      rgb_q, rgb_d;
   logic             out_valid_q, out_valid_d;

   // Clear sequencing: walk every address once; a new clear restarts the walk
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            if (clear) begin
               clr_addr_d = '0;
            end else if (clr_addr_q == LAST_ADDR) begin
               state_d    = ST_IDLE;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + AW'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            clr_addr_d = '0;
         end
      endcase
   end

   assign busy = (state_q == ST_CLEAR);

   // Write port mux: the clear walk owns the port while busy
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_addr_q;
      mem_wdata = '0;
      if (busy) begin
         mem_we = 1'b1;
      end else if (wr_en && ({1'b0, wr_x} < GRID_W) && ({1'b0, wr_y} < GRID_W)) begin
         mem_we    = 1'b1;
         mem_waddr = AW'(AW'(wr_y) * AW'(GRID_N) + AW'(wr_x));
         mem_wdata = wr_data;
      end
   end

   // Stage 0: screen-to-cell mapping, grid line and cursor disc tests
   always_comb begin
      rx        = DrawX - ORIGIN_X_W;
      ry        = DrawY - ORIGIN_Y_W;
      canvas_on = (DrawX >= ORIGIN_X_W) && (DrawY >= ORIGIN_Y_W) &&
                  ({1'b0, rx} < CANVAS_W) && ({1'b0, ry} < CANVAS_W);
      cx        = rx / CELL_W;
      cy        = ry / CELL_W;
      rx_mod    = rx % CELL_W;
      ry_mod    = ry % CELL_W;
      line_on   = grid_en && canvas_on && ((rx_mod == '0) || (ry_mod == '0));
      // out-of-canvas pixels read cell 0; the data is ignored downstream
      rd_addr_d = canvas_on ? AW'(AW'(cy) * AW'(GRID_N) + AW'(cx)) : '0;
      // differences of two 10-bit values always fit an 11-bit signed word
      dx        = {1'b0, DrawX} - {1'b0, BallX};
      dy        = {1'b0, DrawY} - {1'b0, BallY};
      adx       = dx[10] ? (11'd0 - dx) : dx;
      ady       = dy[10] ? (11'd0 - dy) : dy;
      dist2     = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
      rad2      = 22'(Ball_size) * 22'(Ball_size);
      ball_on   = (dist2 <= rad2);
   end

   // Stage 1 next-state: capture the per-pixel flags
   always_comb begin
      s1_valid_d  = pix_valid;
      s1_ball_d   = ball_on;
      s1_line_d   = line_on;
      s1_canvas_d = canvas_on;
   end

   // Stage 2 next-state: colour priority and shade saturation
   always_comb begin
      shifted  = rd_data_q >> SHADE_LSB;
      shade_hi = shifted >> 8;
      shade    = (|shade_hi) ? 8'hFF : shifted[7:0];
      if (s1_ball_q) begin
         colour = 24'hFF0000;
      end else if (s1_line_q) begin
         colour = 24'h404040;
      end else if (s1_canvas_q) begin
         colour = {shade, shade, shade};
      end else begin
         colour = 24'hFFFAFA;
      end
      out_valid_d = s1_valid_q;
      rgb_d       = s1_valid_q ? colour : rgb_q;
   end

   // Canvas RAM: synchronous read returns the pre-write word on a collision
   always_ff @(posedge Clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      rd_data_q <= mem[rd_addr_d];
   end

   // Control and pipeline registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= ST_CLEAR;
         clr_addr_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_ball_q   <= 1'b0;
         s1_line_q   <= 1'b0;
         s1_canvas_q <= 1'b0;
         out_valid_q <= 1'b0;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         s1_valid_q  <= s1_valid_d;
         s1_ball_q   <= s1_ball_d;
         s1_line_q   <= s1_line_d;
         s1_canvas_q <= s1_canvas_d;
         out_valid_q <= out_valid_d;
         rgb_q       <= rgb_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Red       = rgb_q[23:16];
   assign Green     = rgb_q[15:8];
   assign Blue      = rgb_q[7:0];

endmodule

// File: tb/tb_canvas_renderer.sv
// Bench for canvas_renderer: directed vectors with literal expectations,
// plus a reference model of the canvas and colour rules checked every cycle.
module tb_canvas_renderer;

   localparam int G     = 28;
   localparam int C     = 14;
   localparam int OX    = 200;
   localparam int OY    = 44;
   localparam int NCELL = G * G;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        pix_valid = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic [9:0]  BallX = 10'd1023;
   logic [9:0]  BallY = 10'd1023;
   logic [9:0]  Ball_size = '0;
   logic        grid_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_x = '0;
   logic [4:0]  wr_y = '0;
   logic [15:0] wr_data = '0;
   logic        clear = 1'b0;
   logic        busy;
   logic        out_valid;
   logic [7:0]  Red, Green, Blue;

   int checks = 0;
   int failures = 0;

   // reference model state; canvas entries of -1 are not yet known
   int          canvas [NCELL];
   bit          m_busy;
   int          m_idx;
   bit          s1_v, s1_k;
   logic [23:0] s1_rgb;
   bit          m_ov, m_k;
   logic [23:0] m_rgb;
   bit          model_live = 1'b0;

   canvas_renderer dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid),
      .DrawX(DrawX), .DrawY(DrawY), .BallX(BallX), .BallY(BallY),
      .Ball_size(Ball_size), .grid_en(grid_en), .wr_en(wr_en),
      .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .clear(clear),
      .busy(busy), .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void exp_colour(input int x, input int y, input int bx, input int by,
                                      input int bs, input bit g,
                                      output logic [23:0] rgb, output bit known);
      int rx, ry, dx, dy, w, s;
      bit on;
      rx = x - OX;
      ry = y - OY;
      on = (rx >= 0) && (ry >= 0) && (rx < G * C) && (ry < G * C);
      dx = x - bx;
      dy = y - by;
      known = 1'b1;
      rgb = 24'h000000;
      if (dx * dx + dy * dy <= bs * bs) rgb = 24'hFF0000;
      else if (g && on && ((rx % C == 0) || (ry % C == 0))) rgb = 24'h404040;
      else if (on) begin
         w = canvas[(ry / C) * G + rx / C];
         if (w < 0) known = 1'b0;
         else begin
            s = ((w >> 3) > 255) ? 255 : (w >> 3);
            rgb = {3{8'(s)}};
         end
      end else rgb = 24'hFFFAFA;
   endfunction

   task automatic model_step();
      logic [23:0] c;
      bit k;
      if (Reset) begin
         m_busy = 1'b1; m_idx = 0; s1_v = 1'b0; m_ov = 1'b0; m_rgb = '0; m_k = 1'b1;
      end else begin
         m_ov = s1_v;
         if (s1_v) begin m_rgb = s1_rgb; m_k = s1_k; end
         s1_v = pix_valid;
         if (pix_valid) begin
            exp_colour(int'(DrawX), int'(DrawY), int'(BallX), int'(BallY), int'(Ball_size),
                       grid_en, c, k);
            s1_rgb = c; s1_k = k;
         end
         if (m_busy) begin
            canvas[m_idx] = 0;
            if (clear) m_idx = 0;
            else if (m_idx == NCELL - 1) m_busy = 1'b0;
            else m_idx++;
         end else begin
            if (wr_en && int'(wr_x) < G && int'(wr_y) < G)
               canvas[int'(wr_y) * G + int'(wr_x)] = int'(wr_data);
            if (clear) begin m_busy = 1'b1; m_idx = 0; end
         end
      end
      model_live = 1'b1;
   endtask

   // model advances on each active edge
   initial begin
      for (int i = 0; i < NCELL; i++) canvas[i] = -1;
      forever begin
         @(posedge Clk);
         model_step();
      end
   end

   // compare DUT against the model away from the active edge
   initial begin
      forever begin
         @(negedge Clk);
         if (model_live) begin
            chk("model_busy", 32'(busy), 32'(m_busy));
            chk("model_out_valid", 32'(out_valid), 32'(m_ov));
            if (m_k) chk("model_rgb", {8'h00, Red, Green, Blue}, {8'h00, m_rgb});
         end
      end
   end

   task automatic wr_cell(input int x, input int y, input int d);
      wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_data = 16'(d);
      @(negedge Clk);
      wr_en = 1'b0;
   endtask

   task automatic pix_lit(input string name, input int x, input int y, input logic [23:0] exp);
      pix_valid = 1'b1; DrawX = 10'(x); DrawY = 10'(y);
      @(negedge Clk);
      pix_valid = 1'b0;
      @(negedge Clk);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk(name, {8'h00, Red, Green, Blue}, {8'h00, exp});
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         n++;
         @(negedge Clk);
      end
   endtask

   initial begin
      int n;
      logic [15:0] pat;
      pat = 16'b1011_0010_0110_0001;

      repeat (3) @(negedge Clk);
      chk("reset_rgb", {8'h00, Red, Green, Blue}, 32'h0);
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      Reset = 1'b0;
      count_busy(n);
      chk("busy_after_reset", n, 784);

      for (int y = 0; y < G; y++) begin
         for (int x = 0; x < G; x++) begin
            pix_valid = 1'b1; DrawX = 10'(OX + x * C + 7); DrawY = 10'(OY + y * C + 7);
            @(negedge Clk);
         end
      end
      pix_valid = 1'b0;
      repeat (2) @(negedge Clk);
      chk("all_cells_last", {8'h00, Red, Green, Blue}, 32'h000000);

      wr_cell(3, 5, 'h0400);
      pix_lit("shade_80", OX + 3 * C + 7, OY + 5 * C + 7, 24'h808080);
      wr_cell(3, 5, 'h0800);
      pix_lit("shade_sat", OX + 3 * C + 7, OY + 5 * C + 7, 24'hFFFFFF);

      wr_cell(7, 11, 'h0400);
      BallX = 10'd300; BallY = 10'd200; Ball_size = 10'd10;
      pix_lit("ball_right_edge", 310, 200, 24'hFF0000);
      pix_lit("ball_right_out", 311, 200, 24'h808080);
      pix_lit("ball_left_edge", 290, 200, 24'hFF0000);
      pix_lit("ball_diag_in", 307, 207, 24'hFF0000);
      pix_lit("ball_diag_out", 308, 207, 24'h808080);
      BallX = 10'd5; BallY = 10'd100;
      pix_lit("ball_wrap", 0, 100, 24'hFF0000);
      pix_lit("ball_wrap_out", 16, 100, 24'hFFFAFA);
      BallX = 10'd1023; BallY = 10'd1023; Ball_size = 10'd0;

      pix_lit("bg_left", 199, 100, 24'hFFFAFA);
      pix_lit("bg_right", 592, 100, 24'hFFFAFA);
      wr_cell(27, 27, 'h0300);
      pix_lit("corner_cell", 591, 435, 24'h606060);
      pix_lit("bg_below", 591, 436, 24'hFFFAFA);
      grid_en = 1'b1;
      pix_lit("grid_line", 214, 101, 24'h404040);
      pix_lit("grid_left_edge", 200, 101, 24'h404040);
      pix_lit("grid_off_canvas", 199, 101, 24'hFFFAFA);
      pix_lit("grid_cell_inside", 591, 435, 24'h606060);
      grid_en = 1'b0;

      clear = 1'b1;
      @(negedge Clk);
      clear = 1'b0;
      repeat (300) @(negedge Clk);
      chk("busy_mid_clear", 32'(busy), 32'd1);
      clear = 1'b1;
      @(negedge Clk);
      clear = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         if (n == 500) begin
            wr_en = 1'b1; wr_x = 5'd0; wr_y = 5'd0; wr_data = 16'h0400;
         end else wr_en = 1'b0;
         n++;
         @(negedge Clk);
      end
      wr_en = 1'b0;
      chk("busy_restart", n, 784);
      wr_cell(28, 0, 'h0400);
      pix_lit("wr_busy_dropped", OX + 7, OY + 7, 24'h000000);
      pix_lit("wr_x28_dropped", OX + 7, OY + C + 7, 24'h000000);
      pix_lit("cleared_cell", OX + 3 * C + 7, OY + 5 * C + 7, 24'h000000);

      pix_valid = 1'b1; DrawX = 10'(OX + 10 * C + 7); DrawY = 10'(OY + 10 * C + 7);
      wr_en = 1'b1; wr_x = 5'd10; wr_y = 5'd10; wr_data = 16'h0400;
      @(negedge Clk);
      pix_valid = 1'b0; wr_en = 1'b0;
      @(negedge Clk);
      chk("rw_same_old", {8'h00, Red, Green, Blue}, 32'h000000);
      pix_lit("rw_same_new", OX + 10 * C + 7, OY + 10 * C + 7, 24'h808080);

      for (int i = 0; i < 48; i++) begin
         pix_valid = pat[i % 16];
         DrawX = 10'(180 + i * 9); DrawY = 10'(40 + i * 7);
         @(negedge Clk);
      end
      pix_valid = 1'b1; DrawX = 10'(OX + 10 * C + 7); DrawY = 10'(OY + 10 * C + 7);
      @(negedge Clk);
      pix_valid = 1'b0;
      chk("pulse_lat1", 32'(out_valid), 32'(pat[15]));
      @(negedge Clk);
      chk("pulse_lat2", 32'(out_valid), 32'd1);
      @(negedge Clk);
      chk("pulse_lat3", 32'(out_valid), 32'd0);
      chk("pulse_hold", {8'h00, Red, Green, Blue}, 32'h808080);

      clear = 1'b1;
      @(negedge Clk);
      clear = 1'b0;
      repeat (100) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("reset2_rgb", {8'h00, Red, Green, Blue}, 32'h0);
      chk("reset2_out_valid", 32'(out_valid), 32'h0);
      Reset = 1'b0;
      count_busy(n);
      chk("busy_after_reset2", n, 784);
      repeat (2) @(negedge Clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
